mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- MIPS pipeline memory stage, between exe_stage (upstream) and wb_stage (downstream).
- Accepts the EXE result bus and the synchronous data-SRAM read data for loads.
- Aligns and extends load data, then forwards the result to WB with valid/allowin handshaking.
- Captures SRAM read data so that a WB stall never loses it; drives bypass information back to decode.

Parameters:
- ES_TO_MS_BUS_WD, 79, width of the incoming EXE bus.
- MS_TO_WS_BUS_WD, 75, width of the outgoing WB bus.

Ports:
- clk  input  1  clock
- reset  input  1  synchronous, active-high reset
- flush  input  1  exception flush; kills the in-flight instruction
- ws_allowin  input  1  WB can accept this cycle
- ms_allowin  output  1  MEM can accept this cycle
- es_to_ms_valid  input  1  EXE bus valid
- es_to_ms_bus  input  79  fields (MSB first):
  - excode[78:74]
  - ld_type[73:71]
  - res_from_mem[70]
  - gr_we[69]
  - dest[68:64]
  - alu_result[63:32]
  - pc[31:0]
- ms_to_ws_valid  output  1  WB bus valid
- ms_to_ws_bus  output  75  fields (MSB first): excode[74:70], gr_we[69], dest[68:64], final_result[63:32], pc[31:0]
- data_sram_rdata  input  32  read data, valid the cycle after EXE issued the address
- MS_dest  output  5  destination register for bypass, 0 when not valid
- ms_to_ds_result  output  32  final_result for bypass

Behaviour:
- Reset: ms_valid=0, bus register=0, rdata_hold=0, hold_vld=0.
  - All outputs follow: ms_to_ws_valid=0, MS_dest=0, ms_allowin=1.
- Handshake:
  - ms_ready_go=1.
  - ms_allowin = !ms_valid || ws_allowin.
  - ms_to_ws_valid = ms_valid.
- Entry: when ms_allowin is high, ms_valid <= es_to_ms_valid. The bus register loads only when es_to_ms_valid && ms_allowin.
- reset or flush: ms_valid <= 0 and hold_vld <= 0. Flush takes priority over a simultaneous accept.
- Read-data capture:
  - first_cycle is a flag set on accept and cleared on the next clock.
  - If ms_valid && first_cycle && !ws_allowin: rdata_hold <= data_sram_rdata and hold_vld <= 1.
  - hold_vld clears when the instruction leaves (ms_valid && ws_allowin) or on flush.
  - Effective rdata = hold_vld ? rdata_hold : data_sram_rdata.
- ld_type encodings:
  - 0 = LW, 1 = LB, 2 = LBU, 3 = LH, 4 = LHU.
  - Codes 5-7 are treated as LW.
- Load alignment uses off = alu_result[1:0].
  - LB/LBU: select byte off, sign- or zero-extend to 32 bits.
  - LH/LHU: select the halfword at off[1] (off[0] is ignored), sign- or zero-extend.
  - LW: pass the word through unchanged.
- final_result = res_from_mem ? aligned_load : alu_result.
- Bypass:
  - MS_dest = dest & {5{ms_valid}}.
  - ms_to_ds_result = final_result, combinational in the current cycle.
- Back-to-back: a new instruction may enter in the same cycle the old one leaves. first_cycle is set again on that accept.
- Non-load instructions ignore rdata and hold state. Capture still occurs, harmlessly.

Optional Feature:
- Macro: MS_ADDR_EXC_EN.
- When defined, MEM checks for misaligned load addresses:
  - LH/LHU with off[0]=1.
  - LW with off!=0.
- On a misaligned load, when the incoming excode is 0:
  - Output excode=5'h04 (AdEL).
  - gr_we is forced to 0 on ms_to_ws_bus.
  - MS_dest is forced to 0.
- An existing nonzero excode is preserved unchanged.
- When undefined, misaligned loads align using the low bits as described above and no exception is raised.

Decomposition:
- Shared header (mycpu.h) holds:
  - Bus widths ES_TO_MS_BUS_WD and MS_TO_WS_BUS_WD.
  - ld_type codes LD_W, LD_B, LD_BU, LD_H, LD_HU.
  - Excode constant EXC_ADEL.
- One natural sub-module: load_align. It is purely combinational, takes rdata, off and ld_type, and produces aligned_load plus the misaligned flag.

Test Plan:
- LB, addr=0x1003, rdata=0x80FF_1234, ws_allowin=1 -> final_result=0xFFFF_FF80, gr_we=1, ms_to_ws_valid high for 1 cycle.
- LHU, addr=0x2002, rdata=0xBEEF_0001 -> final_result=0x0000_BEEF. LBU, addr=0x2001, same rdata -> 0x0000_0000.
- LW stall: accept a LW, rdata=0xDEAD_BEEF in the first cycle, ws_allowin=0 for 3 cycles while rdata changes to 0x0 -> on release, final_result=0xDEAD_BEEF and ms_allowin stays 0 during the stall.
- Flush while valid and stalled -> the next cycle has ms_to_ws_valid=0, MS_dest=0, hold_vld=0. A simultaneous es_to_ms_valid is dropped.
- Non-load ADD result 0x0000_0042, dest=5 -> ms_to_ds_result=0x42 and MS_dest=5 in the same cycle. Back-to-back second instruction is accepted with no bubble.
- With MS_ADDR_EXC_EN defined: LW at addr=0x1002 -> excode=0x04, gr_we=0. The same stimulus without the macro gives excode=0 and gr_we=1.

Source files
------------

// File: rtl/mem_stage_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_pkg
// Description : Shared widths, load-type codes, exception codes and bus layouts
//               for the MIPS memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 79;
    localparam int MS_TO_WS_BUS_WD = 75;

    localparam logic [2:0] LD_W  = 3'd0;
    localparam logic [2:0] LD_B  = 3'd1;
    localparam logic [2:0] LD_BU = 3'd2;
    localparam logic [2:0] LD_H  = 3'd3;
    localparam logic [2:0] LD_HU = 3'd4;

    localparam logic [4:0] EXC_ADEL = 5'h04;

    typedef struct packed {
        logic [4:0]  excode;
        logic [2:0]  ld_type;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic [4:0]  excode;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

endpackage
`default_nettype wire

// File: rtl/mem_stage_load_align.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_load_align
// Description : Combinational load data alignment and sign/zero extension,
//               plus misaligned-address detection.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_load_align
    import mem_stage_pkg::*;
(
    input  logic [31:0] i_rdata,
    input  logic [1:0]  i_off,
    input  logic [2:0]  i_ld_type,
    output logic [31:0] o_aligned,
    output logic        o_misaligned
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_off)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
    end

    // Halfword select ignores off[0]; misalignment is reported separately.
    assign w_half = i_off[1] ? i_rdata[31:16] : i_rdata[15:0];

    always_comb begin
        o_aligned    = i_rdata;
        o_misaligned = (i_off != 2'd0);
        case (i_ld_type)
            LD_B: begin
                o_aligned    = {{24{w_byte[7]}}, w_byte};
                o_misaligned = 1'b0;
            end
            LD_BU: begin
                o_aligned    = {24'd0, w_byte};
                o_misaligned = 1'b0;
            end
            LD_H: begin
                o_aligned    = {{16{w_half[15]}}, w_half};
                o_misaligned = i_off[0];
            end
            LD_HU: begin
                o_aligned    = {16'd0, w_half};
                o_misaligned = i_off[0];
            end
            default: begin
                o_aligned    = i_rdata;
                o_misaligned = (i_off != 2'd0);
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage
// Description : MIPS pipeline memory stage: load alignment, SRAM read-data
//               capture across WB stalls, bypass to decode.
//               Optional: MS_ADDR_EXC_EN raises AdEL on misaligned loads.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = mem_stage_pkg::ES_TO_MS_BUS_WD,
    parameter int MS_TO_WS_BUS_WD = mem_stage_pkg::MS_TO_WS_BUS_WD
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       flush,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic [31:0]                data_sram_rdata,
    output logic [4:0]                 MS_dest,
    output logic [31:0]                ms_to_ds_result
);

    import mem_stage_pkg::*;

    es_to_ms_t   r_bus;
    logic        r_ms_valid;
    logic        r_first_cycle;
    logic        r_hold_vld;
    logic [31:0] r_rdata_hold;

    logic        w_ms_ready_go;
    logic        w_accept;
    logic [31:0] w_rdata;
    logic [31:0] w_aligned;
    logic        w_misaligned;
    logic [31:0] w_final_result;
    logic        w_adel;
    ms_to_ws_t   w_ws_bus;

    assign w_ms_ready_go = 1'b1;
    assign ms_allowin    = !r_ms_valid || (w_ms_ready_go && ws_allowin);
    assign w_accept      = es_to_ms_valid && ms_allowin;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ms_valid    <= 1'b0;
            r_first_cycle <= 1'b0;
            r_hold_vld    <= 1'b0;
            r_rdata_hold  <= 32'd0;
            r_bus         <= '0;
        end else begin
            if (flush) begin
                r_ms_valid <= 1'b0;
            end else if (ms_allowin) begin
                r_ms_valid <= es_to_ms_valid;
            end

            r_first_cycle <= w_accept && !flush;

            if (w_accept && !flush) begin
                r_bus <= es_to_ms_bus;
            end

            // SRAM data is only present in the first MEM cycle; keep it if WB stalls.
            if (flush) begin
                r_hold_vld <= 1'b0;
            end else if (r_ms_valid && ws_allowin) begin
                r_hold_vld <= 1'b0;
            end else if (r_ms_valid && r_first_cycle && !ws_allowin) begin
                r_rdata_hold <= data_sram_rdata;
                r_hold_vld   <= 1'b1;
            end
        end
    end

    assign w_rdata = r_hold_vld ? r_rdata_hold : data_sram_rdata;

    mem_stage_load_align u_load_align (
        .i_rdata      (w_rdata),
        .i_off        (r_bus.alu_result[1:0]),
        .i_ld_type    (r_bus.ld_type),
        .o_aligned    (w_aligned),
        .o_misaligned (w_misaligned)
    );

    assign w_final_result = r_bus.res_from_mem ? w_aligned : r_bus.alu_result;

`ifdef MS_ADDR_EXC_EN
    // An earlier exception already recorded on the instruction wins.
    assign w_adel = r_bus.res_from_mem && w_misaligned && (r_bus.excode == 5'd0);
`else
    logic w_unused_misaligned;
    assign w_unused_misaligned = w_misaligned;
    assign w_adel              = 1'b0;
`endif

    always_comb begin
        w_ws_bus              = '0;
        w_ws_bus.excode       = w_adel ? EXC_ADEL : r_bus.excode;
        w_ws_bus.gr_we        = r_bus.gr_we && !w_adel;
        w_ws_bus.dest         = r_bus.dest;
        w_ws_bus.final_result = w_final_result;
        w_ws_bus.pc           = r_bus.pc;
    end

    assign ms_to_ws_valid  = r_ms_valid && w_ms_ready_go;
    assign ms_to_ws_bus    = w_ws_bus;
    assign MS_dest         = r_bus.dest & {5{r_ms_valid && !w_adel}};
    assign ms_to_ds_result = w_final_result;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage
// Description : Scoreboard bench for mem_stage with directed load/stall/flush
//               vectors; expected WB bus words are queued as stimulus issues.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage;

`ifdef MS_ADDR_EXC_EN
    localparam bit c_ADEL_ON = 1'b1;
`else
    localparam bit c_ADEL_ON = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        flush;
    logic        ws_allowin;
    logic        ms_allowin;
    logic        es_to_ms_valid;
    logic [78:0] es_to_ms_bus;
    logic        ms_to_ws_valid;
    logic [74:0] ms_to_ws_bus;
    logic [31:0] data_sram_rdata;
    logic [4:0]  MS_dest;
    logic [31:0] ms_to_ds_result;

    int checks = 0;
    int errors = 0;
    logic [74:0] exp_q[$];

    mem_stage dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .ws_allowin      (ws_allowin),
        .ms_allowin      (ms_allowin),
        .es_to_ms_valid  (es_to_ms_valid),
        .es_to_ms_bus    (es_to_ms_bus),
        .ms_to_ws_valid  (ms_to_ws_valid),
        .ms_to_ws_bus    (ms_to_ws_bus),
        .data_sram_rdata (data_sram_rdata),
        .MS_dest         (MS_dest),
        .ms_to_ds_result (ms_to_ds_result)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [78:0] mk(input logic [4:0] exc, input logic [2:0] ld,
                                       input logic rfm, input logic we, input logic [4:0] d,
                                       input logic [31:0] alu, input logic [31:0] pc);
        return {exc, ld, rfm, we, d, alu, pc};
    endfunction

    task automatic push(input logic [4:0] exc, input logic we, input logic [4:0] d,
                        input logic [31:0] res, input logic [31:0] pc);
        exp_q.push_back({exc, we, d, res, pc});
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [78:0] bus, input logic [31:0] rd,
                         input logic wsa, input logic fl);
        es_to_ms_valid  = v;
        es_to_ms_bus    = bus;
        data_sram_rdata = rd;
        ws_allowin      = wsa;
        flush           = fl;
        #2;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Monitor: every transfer to WB must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!reset && ms_to_ws_valid && ws_allowin && !flush) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_out: got bus 0x%019h with empty scoreboard", ms_to_ws_bus);
            end else begin
                logic [74:0] e;
                e = exp_q.pop_front();
                if (ms_to_ws_bus !== e) begin
                    errors++;
                    $display("FAIL ws_bus: got 0x%019h expected 0x%019h", ms_to_ws_bus, e);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1;
        drive(1'b0, '0, 32'd0, 1'b1, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        #2;
        check("rst_valid",   {31'd0, ms_to_ws_valid}, 32'd0);
        check("rst_dest",    {27'd0, MS_dest},        32'd0);
        check("rst_allowin", {31'd0, ms_allowin},     32'd1);
        check("rst_bus_res", ms_to_ws_bus[63:32],     32'd0);
        tick;

        // LB sign extension from byte 3
        drive(1'b1, mk(5'd0, 3'd1, 1'b1, 1'b1, 5'd3, 32'h1003, 32'h100), 32'd0, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd3, 32'hFFFF_FF80, 32'h100);
        tick;
        drive(1'b0, '0, 32'h80FF_1234, 1'b1, 1'b0);
        check("lb_valid",  {31'd0, ms_to_ws_valid}, 32'd1);
        check("lb_dest",   {27'd0, MS_dest},        32'd3);
        check("lb_bypass", ms_to_ds_result,         32'hFFFF_FF80);
        tick;
        drive(1'b0, '0, 32'd0, 1'b1, 1'b0);
        check("lb_one_cycle", {31'd0, ms_to_ws_valid}, 32'd0);
        tick;

        // Back-to-back halfword/byte loads, no bubbles
        drive(1'b1, mk(5'd0, 3'd4, 1'b1, 1'b1, 5'd4, 32'h2002, 32'h200), 32'd0, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd4, 32'h0000_BEEF, 32'h200);
        tick;
        drive(1'b1, mk(5'd0, 3'd2, 1'b1, 1'b1, 5'd5, 32'h2001, 32'h204), 32'hBEEF_0001, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd5, 32'h0000_0000, 32'h204);
        check("b2b_allowin", {31'd0, ms_allowin}, 32'd1);
        tick;
        drive(1'b1, mk(5'd0, 3'd3, 1'b1, 1'b1, 5'd6, 32'h2002, 32'h208), 32'hBEEF_0001, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd6, 32'hFFFF_BEEF, 32'h208);
        tick;
        drive(1'b1, mk(5'd0, 3'd1, 1'b1, 1'b1, 5'd7, 32'h2002, 32'h20C), 32'hBEEF_0001, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd7, 32'hFFFF_FFEF, 32'h20C);
        tick;
        drive(1'b0, '0, 32'hBEEF_0001, 1'b1, 1'b0);
        check("b2b_dest", {27'd0, MS_dest}, 32'd7);
        tick;
        drive(1'b0, '0, 32'd0, 1'b1, 1'b0);
        tick;

        // LW held across a 3-cycle WB stall while SRAM data changes
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd8, 32'h3000, 32'h300), 32'd0, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd8, 32'hDEAD_BEEF, 32'h300);
        tick;
        drive(1'b0, '0, 32'hDEAD_BEEF, 1'b0, 1'b0);
        check("stall_allowin0", {31'd0, ms_allowin}, 32'd0);
        tick;
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd9, 32'h3004, 32'h304), 32'd0, 1'b0, 1'b0);
        check("stall_allowin1", {31'd0, ms_allowin}, 32'd0);
        check("stall_hold",     ms_to_ds_result,     32'hDEAD_BEEF);
        tick;
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd9, 32'h3004, 32'h304), 32'd0, 1'b0, 1'b0);
        check("stall_allowin2", {31'd0, ms_allowin}, 32'd0);
        tick;
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd9, 32'h3004, 32'h304), 32'd0, 1'b1, 1'b0);
        check("release_allowin", {31'd0, ms_allowin}, 32'd1);
        push(5'd0, 1'b1, 5'd9, 32'h1122_3344, 32'h304);
        tick;
        drive(1'b0, '0, 32'h1122_3344, 1'b1, 1'b0);
        check("after_release", ms_to_ds_result, 32'h1122_3344);
        tick;
        drive(1'b0, '0, 32'd0, 1'b1, 1'b0);
        tick;

        // Flush a stalled load that has captured data
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd10, 32'h4000, 32'h400), 32'd0, 1'b1, 1'b0);
        tick;
        drive(1'b0, '0, 32'hCAFE_F00D, 1'b0, 1'b0);
        tick;
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd11, 32'h4004, 32'h404), 32'd0, 1'b0, 1'b1);
        tick;
        drive(1'b0, '0, 32'd0, 1'b1, 1'b0);
        check("flush_valid",   {31'd0, ms_to_ws_valid}, 32'd0);
        check("flush_dest",    {27'd0, MS_dest},        32'd0);
        check("flush_allowin", {31'd0, ms_allowin},     32'd1);
        tick;
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd12, 32'h4100, 32'h408), 32'd0, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd12, 32'h0BAD_F00D, 32'h408);
        tick;
        drive(1'b0, '0, 32'h0BAD_F00D, 1'b1, 1'b0);
        check("flush_hold_cleared", ms_to_ds_result, 32'h0BAD_F00D);
        tick;
        // Flush beats a simultaneous accept
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd13, 32'h4200, 32'h40C), 32'd0, 1'b1, 1'b1);
        tick;
        drive(1'b0, '0, 32'd0, 1'b1, 1'b0);
        check("flush_drop_valid", {31'd0, ms_to_ws_valid}, 32'd0);
        check("flush_drop_dest",  {27'd0, MS_dest},        32'd0);
        tick;

        // Non-load results bypass combinationally
        drive(1'b1, mk(5'd0, 3'd0, 1'b0, 1'b1, 5'd5, 32'h42, 32'h500), 32'd0, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd5, 32'h42, 32'h500);
        tick;
        drive(1'b1, mk(5'd0, 3'd0, 1'b0, 1'b1, 5'd6, 32'h99, 32'h504), 32'hFFFF_FFFF, 1'b1, 1'b0);
        push(5'd0, 1'b1, 5'd6, 32'h99, 32'h504);
        check("add_bypass",  ms_to_ds_result,     32'h42);
        check("add_dest",    {27'd0, MS_dest},    32'd5);
        check("add_allowin", {31'd0, ms_allowin}, 32'd1);
        tick;
        drive(1'b0, '0, 32'hFFFF_FFFF, 1'b1, 1'b0);
        check("add2_bypass", ms_to_ds_result,  32'h99);
        check("add2_dest",   {27'd0, MS_dest}, 32'd6);
        tick;

        // Misaligned loads
        drive(1'b1, mk(5'd0, 3'd0, 1'b1, 1'b1, 5'd12, 32'h1002, 32'h600), 32'd0, 1'b1, 1'b0);
        push(c_ADEL_ON ? 5'h04 : 5'h00, !c_ADEL_ON, 5'd12, 32'h1234_5678, 32'h600);
        tick;
        drive(1'b0, '0, 32'h1234_5678, 1'b1, 1'b0);
        check("mis_lw_dest", {27'd0, MS_dest}, c_ADEL_ON ? 32'd0 : 32'd12);
        tick;
        drive(1'b1, mk(5'h0A, 3'd4, 1'b1, 1'b1, 5'd14, 32'h1001, 32'h604), 32'd0, 1'b1, 1'b0);
        push(5'h0A, 1'b1, 5'd14, 32'h0000_5678, 32'h604);
        tick;
        drive(1'b1, mk(5'd0, 3'd3, 1'b1, 1'b1, 5'd15, 32'h1001, 32'h608), 32'h1234_5678, 1'b1, 1'b0);
        push(c_ADEL_ON ? 5'h04 : 5'h00, !c_ADEL_ON, 5'd15, 32'h0000_5678, 32'h608);
        check("exc_keep_dest", {27'd0, MS_dest}, 32'd14);
        tick;
        drive(1'b0, '0, 32'h1234_5678, 1'b1, 1'b0);
        tick;
        drive(1'b0, '0, 32'd0, 1'b1, 1'b0);
        tick;
        tick;

        check("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
